// File: rtl/csr_issue_gate_if.sv
// Handshake bundle between the CSR issue fifo, the commit stage and execute_csr.
// The master modport drives the fifo/commit inputs; the slave modport is the gate.
interface csr_issue_gate_if #(
  parameter int ROB_ID_WIDTH    = 5,
  parameter int STALL_CNT_WIDTH = 16
);
  logic                       issue_csr_fifo_data_out_valid;
  logic [ROB_ID_WIDTH-1:0]    issue_csr_fifo_data_out_rob_id;
  logic                       commit_enable;
  logic                       commit_next_handle_rob_id_valid;
  logic [ROB_ID_WIDTH-1:0]    commit_next_handle_rob_id;
  logic                       commit_committed_rob_id_valid;
  logic [ROB_ID_WIDTH-1:0]    commit_committed_rob_id;
  logic                       commit_flush;
  logic                       gate_excsr_valid;
  logic                       gate_busy;
  logic [ROB_ID_WIDTH-1:0]    gate_pending_rob_id;
  logic [STALL_CNT_WIDTH-1:0] stall_count;

  modport master (
    output issue_csr_fifo_data_out_valid, issue_csr_fifo_data_out_rob_id,
    output commit_enable, commit_next_handle_rob_id_valid, commit_next_handle_rob_id,
    output commit_committed_rob_id_valid, commit_committed_rob_id, commit_flush,
    input  gate_excsr_valid, gate_busy, gate_pending_rob_id, stall_count
  );

  modport slave (
    input  issue_csr_fifo_data_out_valid, issue_csr_fifo_data_out_rob_id,
    input  commit_enable, commit_next_handle_rob_id_valid, commit_next_handle_rob_id,
    input  commit_committed_rob_id_valid, commit_committed_rob_id, commit_flush,
    output gate_excsr_valid, gate_busy, gate_pending_rob_id, stall_count
  );
endinterface

// File: rtl/csr_issue_gate.sv
// Serialises CSR ops: grants the fifo head only when it is the oldest uncommitted op,
// holds the gate closed until that op retires, and counts stalled head cycles.
//
//  state       | meaning
//  ST_IDLE     | nothing in flight; head may be granted when it is next to commit
//  ST_WAIT     | one granted CSR op awaiting retirement (pending_rob_id)
module csr_issue_gate #(
  parameter int ROB_ID_WIDTH    = 5,
  parameter int STALL_CNT_WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  csr_issue_gate_if.slave  gate_if
);
  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t                     state, state_nxt;
  logic [ROB_ID_WIDTH-1:0]    pending_rob_id;
  logic [STALL_CNT_WIDTH-1:0] stall_count;
  logic                       head_ok;
  logic                       retire_hit;
  logic                       grant;
  logic                       busy;

  assign head_ok = gate_if.commit_enable & gate_if.commit_next_handle_rob_id_valid
                 & (gate_if.commit_next_handle_rob_id == gate_if.issue_csr_fifo_data_out_rob_id);
  assign retire_hit = gate_if.commit_committed_rob_id_valid
                    & (gate_if.commit_committed_rob_id == pending_rob_id);

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant) state_nxt = ST_WAIT;
      ST_WAIT: if (retire_hit) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (gate_if.commit_flush) state_nxt = ST_IDLE;
  end

  // grant is combinational so execute_csr sees it in the same cycle the head qualifies
  always_comb begin
    grant = 1'b0;
    busy  = 1'b0;
    case (state)
      ST_IDLE: grant = gate_if.issue_csr_fifo_data_out_valid & head_ok & ~gate_if.commit_flush;
      ST_WAIT: busy  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_rob_id <= '0;
      stall_count    <= '0;
    end else begin
      if (gate_if.commit_flush) pending_rob_id <= '0;
      else if (grant)           pending_rob_id <= gate_if.issue_csr_fifo_data_out_rob_id;
      if (gate_if.issue_csr_fifo_data_out_valid & ~grant & ~gate_if.commit_flush
          & (stall_count != '1))
        stall_count <= stall_count + STALL_CNT_WIDTH'(1);
    end
  end

  assign gate_if.gate_excsr_valid    = grant;
  assign gate_if.gate_busy           = busy;
  assign gate_if.gate_pending_rob_id = pending_rob_id;
  assign gate_if.stall_count         = stall_count;
endmodule

// File: tb/tb_csr_issue_gate.sv
// Directed vector bench for csr_issue_gate; a second 4-bit-counter instance shares the
// stimulus and is used for the stall counter saturation sequence.
module tb_csr_issue_gate;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  csr_issue_gate_if #(.ROB_ID_WIDTH(5), .STALL_CNT_WIDTH(16)) gif ();
  csr_issue_gate_if #(.ROB_ID_WIDTH(5), .STALL_CNT_WIDTH(4))  gif4 ();

  csr_issue_gate #(.ROB_ID_WIDTH(5), .STALL_CNT_WIDTH(16)) dut (.clk(clk), .rst(rst), .gate_if(gif.slave));
  csr_issue_gate #(.ROB_ID_WIDTH(5), .STALL_CNT_WIDTH(4))  dut4 (.clk(clk), .rst(rst), .gate_if(gif4.slave));

  assign gif4.issue_csr_fifo_data_out_valid   = gif.issue_csr_fifo_data_out_valid;
  assign gif4.issue_csr_fifo_data_out_rob_id  = gif.issue_csr_fifo_data_out_rob_id;
  assign gif4.commit_enable                   = gif.commit_enable;
  assign gif4.commit_next_handle_rob_id_valid = gif.commit_next_handle_rob_id_valid;
  assign gif4.commit_next_handle_rob_id       = gif.commit_next_handle_rob_id;
  assign gif4.commit_committed_rob_id_valid   = gif.commit_committed_rob_id_valid;
  assign gif4.commit_committed_rob_id         = gif.commit_committed_rob_id;
  assign gif4.commit_flush                    = gif.commit_flush;

  typedef struct {
    logic        rst_v;
    logic        valid;
    logic [4:0]  rid;
    logic        en;
    logic        nhv;
    logic [4:0]  nh;
    logic        crv;
    logic [4:0]  cr;
    logic        flush;
    logic        eg;     // expected grant before the edge
    logic        eb;     // expected busy after the edge
    logic [4:0]  ep;     // expected pending after the edge
    logic [15:0] es;     // expected stall_count after the edge
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(logic r, logic v, logic [4:0] rid, logic en, logic nhv, logic [4:0] nh,
                              logic crv, logic [4:0] cr, logic fl,
                              logic eg, logic eb, logic [4:0] ep, logic [15:0] es);
    vec_t x;
    x.rst_v = r; x.valid = v; x.rid = rid; x.en = en; x.nhv = nhv; x.nh = nh;
    x.crv = crv; x.cr = cr; x.flush = fl; x.eg = eg; x.eb = eb; x.ep = ep; x.es = es;
    return x;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    rst = x.rst_v;
    gif.issue_csr_fifo_data_out_valid   = x.valid;
    gif.issue_csr_fifo_data_out_rob_id  = x.rid;
    gif.commit_enable                   = x.en;
    gif.commit_next_handle_rob_id_valid = x.nhv;
    gif.commit_next_handle_rob_id       = x.nh;
    gif.commit_committed_rob_id_valid   = x.crv;
    gif.commit_committed_rob_id         = x.cr;
    gif.commit_flush                    = x.flush;
  endtask

  initial begin
    //              rst v rid en nhv nh crv cr fl   eg eb ep es
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0));
    // head 7 waits while commit points at 5
    vecs.push_back(mk(1, 1, 7, 1, 1, 5, 0, 0, 0,   0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 7, 1, 1, 5, 0, 0, 0,   0, 0, 0, 2));
    vecs.push_back(mk(1, 1, 7, 1, 1, 5, 0, 0, 0,   0, 0, 0, 3));
    vecs.push_back(mk(1, 1, 7, 1, 1, 7, 0, 0, 0,   1, 1, 7, 3));
    // serialise: head 8 is next but 7 still in flight
    vecs.push_back(mk(1, 1, 8, 1, 1, 8, 0, 0, 0,   0, 1, 7, 4));
    vecs.push_back(mk(1, 1, 8, 1, 1, 8, 1, 7, 0,   0, 0, 7, 5));
    vecs.push_back(mk(1, 1, 8, 1, 1, 8, 0, 0, 0,   1, 1, 8, 5));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 8, 0,   0, 0, 8, 5));
    // head_ok qualifiers
    vecs.push_back(mk(1, 1, 3, 0, 1, 3, 0, 0, 0,   0, 0, 8, 6));
    vecs.push_back(mk(1, 1, 3, 1, 0, 3, 0, 0, 0,   0, 0, 8, 7));
    vecs.push_back(mk(1, 1, 3, 1, 1, 3, 0, 0, 0,   1, 1, 3, 7));
    // non-matching retire, then matching
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 4, 0,   0, 1, 3, 7));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 3, 0,   0, 0, 3, 7));
    // flush while busy with a matching head
    vecs.push_back(mk(1, 1, 9, 1, 1, 9, 0, 0, 0,   1, 1, 9, 7));
    vecs.push_back(mk(1, 1, 10,1, 1, 10,0, 0, 1,   0, 0, 0, 7));
    vecs.push_back(mk(1, 1, 10,1, 1, 10,0, 0, 1,   0, 0, 0, 7));
    // flush and matching retire together
    vecs.push_back(mk(1, 1, 9, 1, 1, 9, 0, 0, 0,   1, 1, 9, 7));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 9, 1,   0, 0, 0, 7));
    // wrap 31 -> 0
    vecs.push_back(mk(1, 1, 31,1, 1, 31,0, 0, 0,   1, 1, 31,7));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 31,0,   0, 0, 31,7));
    vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 0,   1, 1, 0, 7));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 7));
    // reset while busy drops the pending op
    vecs.push_back(mk(1, 1, 5, 1, 1, 5, 0, 0, 0,   1, 1, 5, 7));
    vecs.push_back(mk(0, 1, 6, 1, 1, 6, 0, 0, 0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 6, 1, 1, 6, 0, 0, 0,   1, 1, 6, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 6, 0,   0, 0, 6, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check("grant", i, 32'(gif.gate_excsr_valid), 32'(vecs[i].eg));
      @(posedge clk);
      #1;
      check("busy", i, 32'(gif.gate_busy), 32'(vecs[i].eb));
      check("pending", i, 32'(gif.gate_pending_rob_id), 32'(vecs[i].ep));
      check("stall", i, 32'(gif.stall_count), 32'(vecs[i].es));
    end

    // saturation on the 4-bit counter instance
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("sat_reset", 0, 32'(gif4.stall_count), 32'd0);
    drive(mk(1, 1, 7, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 14) check("sat_14", k, 32'(gif4.stall_count), 32'd14);
      if (k == 15) check("sat_15", k, 32'(gif4.stall_count), 32'd15);
    end
    check("sat_20", 20, 32'(gif4.stall_count), 32'd15);
    check("wide_20", 20, 32'(gif.stall_count), 32'd20);
    check("sat_nogrant", 20, 32'(gif4.gate_excsr_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
